// File: rtl/program_counter_pkg.sv
// Shared definitions for the program counter and its ALU.
// Optional feature macro: ALU_FLAGS_EN (adds ALU_CARRY / ALU_OVF outputs).
package program_counter_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int SHAMT_W       = 4;

    // ALU operation encodings carried on ALU_OP.
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5,
        ALU_SLL = 3'd6,
        ALU_SRL = 3'd7
    } alu_op_e;

endpackage

// File: rtl/program_counter_alu.sv
// Combinational ALU feeding the program counter's next value.
// Optional feature macro: ALU_FLAGS_EN (carry / signed-overflow outputs).
module alu
    import program_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] SRCA,
    input  logic [WIDTH-1:0] SRCB,
    input  logic [2:0]       ALU_OP,
`ifdef ALU_FLAGS_EN
    output logic             ALU_CARRY,
    output logic             ALU_OVF,
`endif
    output logic [WIDTH-1:0] ALU_OUT,
    output logic             ALU_ZERO
);

    alu_op_e              op_s;
    logic [SHAMT_W-1:0]   shamt_s;
    logic [WIDTH-1:0]     result_s;

    assign op_s    = alu_op_e'(ALU_OP);
    // Shift distance only ever uses the low four bits of operand B.
    assign shamt_s = SRCB[SHAMT_W-1:0];

    // Select the result of the requested operation.
    always_comb begin
        result_s = {WIDTH{1'b0}};
        case (op_s)
            ALU_ADD: result_s = SRCA + SRCB;
            ALU_SUB: result_s = SRCA - SRCB;
            ALU_AND: result_s = SRCA & SRCB;
            ALU_OR:  result_s = SRCA | SRCB;
            ALU_XOR: result_s = SRCA ^ SRCB;
            ALU_SLT: result_s = ($signed(SRCA) < $signed(SRCB)) ?
                                {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b0}};
            ALU_SLL: result_s = SRCA << shamt_s;
            ALU_SRL: result_s = SRCA >> shamt_s;
            default: result_s = {WIDTH{1'b0}};
        endcase
    end

    assign ALU_OUT  = result_s;
    assign ALU_ZERO = (result_s == {WIDTH{1'b0}});

`ifdef ALU_FLAGS_EN
    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] diff_s;

    // Extended-width add and A + ~B + 1 subtract expose carry / no-borrow.
    assign sum_s  = {1'b0, SRCA} + {1'b0, SRCB};
    assign diff_s = {1'b0, SRCA} + {1'b0, ~SRCB} + {{WIDTH{1'b0}}, 1'b1};

    // Flags are meaningful only for ADD and SUB; zero for every other op.
    always_comb begin
        ALU_CARRY = 1'b0;
        ALU_OVF   = 1'b0;
        case (op_s)
            ALU_ADD: begin
                ALU_CARRY = sum_s[WIDTH];
                ALU_OVF   = (SRCA[WIDTH-1] == SRCB[WIDTH-1]) &&
                            (sum_s[WIDTH-1] != SRCA[WIDTH-1]);
            end
            ALU_SUB: begin
                ALU_CARRY = diff_s[WIDTH];
                ALU_OVF   = (SRCA[WIDTH-1] != SRCB[WIDTH-1]) &&
                            (diff_s[WIDTH-1] != SRCA[WIDTH-1]);
            end
            default: begin
                ALU_CARRY = 1'b0;
                ALU_OVF   = 1'b0;
            end
        endcase
    end
`endif

endmodule

// File: rtl/program_counter.sv
// Program counter register loaded from the ALU result.
// Optional feature macro: ALU_FLAGS_EN (passes ALU_CARRY / ALU_OVF through).
module program_counter
    import program_counter_pkg::*;
#(
    parameter int               WIDTH        = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = {WIDTH{1'b0}}
) (
    input  logic             CLOCK,
    input  logic             PC_RESET,
    input  logic             PC_EN,
    input  logic [WIDTH-1:0] SRCA,
    input  logic [WIDTH-1:0] SRCB,
    input  logic [2:0]       ALU_OP,
    output logic [WIDTH-1:0] ALU_OUT,
    output logic             ALU_ZERO,
`ifdef ALU_FLAGS_EN
    output logic             ALU_CARRY,
    output logic             ALU_OVF,
`endif
    output logic [WIDTH-1:0] PC_OUT
);

    logic [WIDTH-1:0] alu_out_s;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_q;

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .SRCA      (SRCA),
        .SRCB      (SRCB),
        .ALU_OP    (ALU_OP),
`ifdef ALU_FLAGS_EN
        .ALU_CARRY (ALU_CARRY),
        .ALU_OVF   (ALU_OVF),
`endif
        .ALU_OUT   (alu_out_s),
        .ALU_ZERO  (ALU_ZERO)
    );

    assign ALU_OUT = alu_out_s;

    // Next PC: take the ALU result when enabled, otherwise hold.
    always_comb begin
        pc_d = pc_q;
        if (PC_EN) begin
            pc_d = alu_out_s;
        end else begin
            pc_d = pc_q;
        end
    end

    // PC register; synchronous reset wins over any pending load.
    always_ff @(posedge CLOCK) begin
        if (PC_RESET) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign PC_OUT = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed, table-driven bench for program_counter.
module tb_program_counter;

    logic        CLOCK;
    logic        PC_RESET;
    logic        PC_EN;
    logic [15:0] SRCA;
    logic [15:0] SRCB;
    logic [2:0]  ALU_OP;
    logic [15:0] ALU_OUT;
    logic        ALU_ZERO;
`ifdef ALU_FLAGS_EN
    logic        ALU_CARRY;
    logic        ALU_OVF;
`endif
    logic [15:0] PC_OUT;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic [15:0] exp_out;
        logic        exp_zero;
        logic        exp_c;
        logic        exp_v;
    } vec_t;

    vec_t vecs [15];

    program_counter #(
        .WIDTH        (16),
        .RESET_VECTOR (16'h0000)
    ) dut (
        .CLOCK     (CLOCK),
        .PC_RESET  (PC_RESET),
        .PC_EN     (PC_EN),
        .SRCA      (SRCA),
        .SRCB      (SRCB),
        .ALU_OP    (ALU_OP),
        .ALU_OUT   (ALU_OUT),
        .ALU_ZERO  (ALU_ZERO),
`ifdef ALU_FLAGS_EN
        .ALU_CARRY (ALU_CARRY),
        .ALU_OVF   (ALU_OVF),
`endif
        .PC_OUT    (PC_OUT)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive inputs at the falling edge so they settle before the next rising edge.
    task automatic drive(input logic rst, input logic en, input logic [15:0] a,
                         input logic [15:0] b, input logic [2:0] op);
        @(negedge CLOCK);
        PC_RESET = rst;
        PC_EN    = en;
        SRCA     = a;
        SRCB     = b;
        ALU_OP   = op;
        #1;
    endtask

    task automatic edge_wait;
        @(posedge CLOCK);
        #1;
    endtask

    initial begin
        vecs[0]  = '{"add",      16'h00F0, 16'h0F0F, 3'd0, 16'h0FFF, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{"sub",      16'h00F0, 16'h0F0F, 3'd1, 16'hF1E1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{"and",      16'h00F0, 16'h0F0F, 3'd2, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{"or",       16'h00F0, 16'h0F0F, 3'd3, 16'h0FFF, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{"xor",      16'h00F0, 16'h0F0F, 3'd4, 16'h0FFF, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{"slt_neg",  16'h8000, 16'h0001, 3'd5, 16'h0001, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{"srl_1",    16'h8000, 16'h0001, 3'd7, 16'h4000, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{"sll_out",  16'h8000, 16'h0001, 3'd6, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{"sll_mask", 16'h0001, 16'h0014, 3'd6, 16'h0010, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{"srl_mask", 16'h8000, 16'h0011, 3'd7, 16'h4000, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{"slt_pos",  16'h0001, 16'h8000, 3'd5, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{"slt_m1",   16'hFFFF, 16'h0001, 3'd5, 16'h0001, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{"add_wrap", 16'hFFFF, 16'h0003, 3'd0, 16'h0002, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{"sub_wrap", 16'h0000, 16'h0001, 3'd1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{"srl_15",   16'h8000, 16'h000F, 3'd7, 16'h0001, 1'b0, 1'b0, 1'b0};

        PC_RESET = 1'b1;
        PC_EN    = 1'b1;
        SRCA     = 16'h0000;
        SRCB     = 16'h0000;
        ALU_OP   = 3'd0;

        // Reset with load enabled; ALU keeps working during reset.
        drive(1'b1, 1'b1, 16'h1111, 16'h0000, 3'd0);
        check("alu_during_reset", ALU_OUT, 16'h1111);
        edge_wait();
        check("reset_pc", PC_OUT, 16'h0000);

        // Increment by 2 four times.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, PC_OUT, 16'h0002, 3'd0);
            edge_wait();
            check($sformatf("incr_%0d", i), PC_OUT, 16'((i + 1) * 2));
        end

        // Hold for three edges while the ALU offers a different value.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, PC_OUT, 16'h0002, 3'd0);
            edge_wait();
            check($sformatf("hold_%0d", i), PC_OUT, 16'h0008);
        end

        // Input changes between edges must not reach PC_OUT.
        drive(1'b0, 1'b1, 16'hABCD, 16'h0000, 3'd0);
        check("no_comb_path", PC_OUT, 16'h0008);
        edge_wait();
        check("load_abcd", PC_OUT, 16'hABCD);

        // Wrap from FFFE by 2.
        drive(1'b0, 1'b1, 16'hFFFE, 16'h0000, 3'd0);
        edge_wait();
        check("load_fffe", PC_OUT, 16'hFFFE);
        drive(1'b0, 1'b1, PC_OUT, 16'h0002, 3'd0);
        check("wrap_alu_out", ALU_OUT, 16'h0000);
        check("wrap_alu_zero", {15'd0, ALU_ZERO}, 16'h0001);
        edge_wait();
        check("wrap_pc", PC_OUT, 16'h0000);

        // Reset has priority over a pending load of 1234.
        drive(1'b0, 1'b1, 16'h0040, 16'h0000, 3'd0);
        edge_wait();
        check("load_0040", PC_OUT, 16'h0040);
        drive(1'b1, 1'b1, 16'h1000, 16'h0234, 3'd0);
        check("prio_alu_out", ALU_OUT, 16'h1234);
        edge_wait();
        check("prio_pc", PC_OUT, 16'h0000);

        // ALU operation table with the PC held.
        for (int i = 0; i < 15; i++) begin
            drive(1'b0, 1'b0, vecs[i].a, vecs[i].b, vecs[i].op);
            check({vecs[i].name, "_out"}, ALU_OUT, vecs[i].exp_out);
            check({vecs[i].name, "_zero"}, {15'd0, ALU_ZERO}, {15'd0, vecs[i].exp_zero});
`ifdef ALU_FLAGS_EN
            check({vecs[i].name, "_carry"}, {15'd0, ALU_CARRY}, {15'd0, vecs[i].exp_c});
            check({vecs[i].name, "_ovf"}, {15'd0, ALU_OVF}, {15'd0, vecs[i].exp_v});
`endif
        end
        edge_wait();
        check("table_hold_pc", PC_OUT, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, datapath width of the PC and ALU.
REQ-002 The block SHALL have parameter RESET_VECTOR, default 16'h0000, PC value loaded on reset.
REQ-003 The block SHALL have port CLOCK, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port PC_RESET, input, 1 bit, synchronous active-high reset.
REQ-005 The block SHALL have port PC_EN, input, 1 bit, PC load enable.
REQ-006 The block SHALL have port SRCA, input, WIDTH bits, ALU operand A (normally driven with PC_OUT).
REQ-007 The block SHALL have port SRCB, input, WIDTH bits, ALU operand B (normally the increment, 2).
REQ-008 The block SHALL have port ALU_OP, input, 3 bits, ALU operation select.
REQ-009 The block SHALL have port ALU_OUT, output, WIDTH bits, combinational ALU result and PC next value.
REQ-010 The block SHALL have port ALU_ZERO, output, 1 bit, high when ALU_OUT equals zero.
REQ-011 The block SHALL have port PC_OUT, output, WIDTH bits, registered program counter.

Function
REQ-012 ALU_OP encodings SHALL be: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 SLT (signed, result 1 or 0), 6 SLL (A << B[3:0]), 7 SRL logical (A >> B[3:0]).
REQ-013 ADD and SUB SHALL wrap modulo 2^WIDTH; no saturation.
REQ-014 ALU_OUT and ALU_ZERO SHALL be purely combinational with zero-cycle latency from SRCA, SRCB, and ALU_OP.
REQ-015 On a rising CLOCK edge with PC_RESET=0 and PC_EN=1, PC_OUT SHALL take the ALU_OUT value present before the edge.
REQ-016 On a rising CLOCK edge with PC_RESET=0 and PC_EN=0, PC_OUT SHALL hold its value.
REQ-017 PC_RESET SHALL take priority over PC_EN when both are high.
REQ-018 PC increment from 16'hFFFE by 2 SHALL wrap to 16'h0000 and set ALU_ZERO combinationally.
REQ-019 PC_OUT SHALL be 1-cycle latency from ALU_OUT; there SHALL be no combinational path from any input to PC_OUT.

Reset
REQ-020 Reset SHALL be synchronous and active-high on PC_RESET, sampled at the rising edge of CLOCK; PC_OUT SHALL become RESET_VECTOR.
REQ-021 Reset asserted mid-operation SHALL override any pending load on that edge.
REQ-022 Reset SHALL not affect the combinational ALU outputs.
REQ-023 PC_OUT SHALL be undefined before the first reset edge.

Configuration
REQ-024 Macro ALU_FLAGS_EN, when defined, SHALL add outputs ALU_CARRY (1 bit, carry-out of ADD / no-borrow of SUB, 0 for other ops) and ALU_OVF (1 bit, signed overflow of ADD/SUB, 0 otherwise).
REQ-025 Without ALU_FLAGS_EN, those ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-026 A shared package SHALL hold the ALU_OP encoding constants, an alu_op enum typedef, and the default WIDTH constant.
REQ-027 The ALU SHALL be a sub-module named alu (SRCA, SRCB, ALU_OP -> ALU_OUT, ALU_ZERO); program_counter SHALL instantiate it and register its result.

Verification
REQ-028 Reset: PC_RESET=1 for one edge, PC_EN=1 -> PC_OUT=16'h0000 after the edge.
REQ-029 Increment: SRCA=PC_OUT, SRCB=2, ALU_OP=ADD, PC_EN=1 for 4 edges from 0 -> PC_OUT 2, 4, 6, 8.
REQ-030 Hold: PC_EN=0 at PC_OUT=8 for 3 edges -> PC_OUT stays 8.
REQ-031 Wrap: SRCA=16'hFFFE, SRCB=2, ADD -> ALU_OUT=0, ALU_ZERO=1; after a PC_EN edge, PC_OUT=0.
REQ-032 ALU ops: A=16'h00F0, B=16'h0F0F -> SUB=16'hF1E1, AND=16'h0000 (ZERO=1), OR=16'h0FFF, XOR=16'h0FFF; A=16'h8000, B=1 -> SLT=1, SRL=16'h4000.
REQ-033 Priority: PC_RESET=1 and PC_EN=1 with ALU_OUT=16'h1234 -> PC_OUT=RESET_VECTOR.
